spi_ram_master: RTL

//  SPI master that drives the single-clock SPI slave + RAM subsystem from a parallel host command port.

---
 rtl/spi_ram_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/spi_ram_master.sv
// SPI master for the single-clock SPI slave + RAM: shifts a 2-bit opcode plus payload out
// on MOSI per frame and, for read-data frames, captures the reply from MISO onto rsp_*.
module spi_ram_master #(
   parameter int DATA_W        = 8,
   parameter int LEAD_CYCLES   = 1,
   parameter int RD_TURNAROUND = 2,
   parameter int GAP_CYCLES    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_op_i,
   input  logic [DATA_W-1:0] cmd_data_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              busy_o,
   output logic              ss_n_o,
   output logic              mosi_o,
   input  logic              miso_i
);
   localparam int FRAME_W = DATA_W + 2;
   localparam int MAX_A   = (FRAME_W > LEAD_CYCLES) ? FRAME_W : LEAD_CYCLES;
   localparam int MAX_B   = (RD_TURNAROUND > GAP_CYCLES) ? RD_TURNAROUND : GAP_CYCLES;
   localparam int CNT_W   = $clog2(((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1);

   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t LEAD_LAST  = cnt_t'(LEAD_CYCLES - 1);
   localparam cnt_t SHIFT_LAST = cnt_t'(FRAME_W - 1);
   localparam cnt_t TURN_LAST  = cnt_t'(RD_TURNAROUND - 1);
   localparam cnt_t RECV_LAST  = cnt_t'(DATA_W - 1);
   localparam cnt_t GAP_LAST   = cnt_t'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

   typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TURN, S_RECV, S_DONE, S_GAP} state_t;

   // The IDLE cycle in which the next command is accepted is itself an SS_n-high cycle,
   // so GAP only supplies the remaining GAP_CYCLES-1 high cycles (none when GAP_CYCLES==1).
   localparam state_t POST_STATE = (GAP_CYCLES > 1) ? S_GAP : S_IDLE;

   state_t              state_q, state_d;
   cnt_t                cnt_q, cnt_d;
   logic [FRAME_W-1:0]  shift_q, shift_d;
   logic [DATA_W-2:0]   rx_q, rx_d;
   logic [DATA_W-1:0]   rx_full;
   logic                rd_q, rd_d;
   logic                ss_n_q, ss_n_d;
   logic                mosi_q, mosi_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                busy_q, busy_d;

   assign rx_full     = {rx_q, miso_i};
   assign cmd_ready_o = (state_q == S_IDLE);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign busy_o      = busy_q;
   assign ss_n_o      = ss_n_q;
   assign mosi_o      = mosi_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         rx_q        <= '0;
         rd_q        <= 1'b0;
         ss_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         rx_q        <= rx_d;
         rd_q        <= rd_d;
         ss_n_q      <= ss_n_d;
         mosi_q      <= mosi_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      rx_d        = rx_q;
      rd_d        = rd_q;
      ss_n_d      = ss_n_q;
      mosi_d      = mosi_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;

      unique case (state_q)
         S_IDLE: begin
            ss_n_d = 1'b1;
            mosi_d = 1'b0;
            if (cmd_valid_i) begin
               state_d = S_LEAD;
               cnt_d   = '0;
               shift_d = {cmd_op_i, cmd_data_i};
               rd_d    = (cmd_op_i == 2'b11);
               ss_n_d  = 1'b0;
               mosi_d  = cmd_op_i[1];
            end
         end
         S_LEAD: begin
            mosi_d = shift_q[FRAME_W-1];
            if (cnt_q == LEAD_LAST) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
               shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         S_SHIFT: begin
            if (cnt_q == SHIFT_LAST) begin
               cnt_d  = '0;
               mosi_d = 1'b0;
               if (rd_q) begin
                  state_d = S_TURN;
               end else begin
                  state_d = POST_STATE;
                  ss_n_d  = 1'b1;
               end
            end else begin
               cnt_d   = cnt_q + cnt_t'(1);
               mosi_d  = shift_q[FRAME_W-1];
               shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            end
         end
         S_TURN: begin
            mosi_d = 1'b0;
            if (cnt_q == TURN_LAST) begin
               state_d = S_RECV;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         S_RECV: begin
            rx_d = rx_full[DATA_W-2:0];
            if (cnt_q == RECV_LAST) begin
               state_d     = S_DONE;
               cnt_d       = '0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = rx_full;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         S_DONE: begin
            state_d = POST_STATE;
            cnt_d   = '0;
            ss_n_d  = 1'b1;
            mosi_d  = 1'b0;
         end
         S_GAP: begin
            ss_n_d = 1'b1;
            mosi_d = 1'b0;
            if (cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end
endmodule
